muntjac_tl_host_arbiter: RTL

MUNTJAC_TL_HOST_ARBITER -- requirements
Module: muntjac_tl_host_arbiter

---
 rtl/muntjac_tl_host_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muntjac_tl_host_arbiter.sv
// Merges NumLinks TileLink host links onto one device port: round-robin A arbitration
// with burst locking, and D beats routed back to the link owning the source ID.
module muntjac_tl_host_arbiter #(
    parameter int unsigned NumLinks    = 4,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 56,
    parameter int unsigned SourceWidth = 4,
    parameter int unsigned SinkWidth   = 1,
    parameter logic [NumLinks*SourceWidth-1:0] SourceBase = {4'd3, 4'd2, 4'd1, 4'd0},
    parameter logic [NumLinks*SourceWidth-1:0] SourceMask = '0,
    localparam int unsigned ABits = 3 + 3 + 3 + SourceWidth + AddrWidth + DataWidth / 8 + 1 + DataWidth,
    localparam int unsigned DBits = 3 + 2 + 3 + SourceWidth + SinkWidth + 1 + 1 + DataWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [NumLinks-1:0]       host_a_valid_i,
    output logic [NumLinks-1:0]       host_a_ready_o,
    input  logic [NumLinks*ABits-1:0] host_a_i,

    output logic                      dev_a_valid_o,
    input  logic                      dev_a_ready_i,
    output logic [ABits-1:0]          dev_a_o,

    input  logic                      dev_d_valid_i,
    output logic                      dev_d_ready_o,
    input  logic [DBits-1:0]          dev_d_i,

    output logic [NumLinks-1:0]       host_d_valid_o,
    input  logic [NumLinks-1:0]       host_d_ready_i,
    output logic [NumLinks*DBits-1:0] host_d_o,

    output logic                      route_err_o
);

    localparam int unsigned IdxW      = $clog2(NumLinks);
    localparam int unsigned CntW      = 8;
    localparam int unsigned BeatShift = $clog2(DataWidth / 8);
    localparam int unsigned DSrcLsb   = DataWidth + 2 + SinkWidth;

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            route_err_q, route_err_d;

    logic [ABits-1:0] a_payload [NumLinks];

    for (genvar k = 0; k < NumLinks; k++) begin : g_a_unpack
        assign a_payload[k] = host_a_i[k*ABits +: ABits];
    end

    logic [IdxW-1:0] search_idx;
    logic            search_hit;
    logic [IdxW:0]   cand;

    // Walk from the lowest priority offset to the highest so the last hit is the winner.
    always_comb begin
        search_idx = '0;
        search_hit = 1'b0;
        cand       = '0;
        for (int i = NumLinks - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumLinks)) begin
                cand = cand - (IdxW+1)'(NumLinks);
            end
            if (host_a_valid_i[cand[IdxW-1:0]]) begin
                search_hit = 1'b1;
                search_idx = cand[IdxW-1:0];
            end
        end
    end

    logic [IdxW-1:0] grant_idx;
    logic            grant_active;
    logic [IdxW-1:0] grant_next;

    always_comb begin
        grant_idx    = lock_q ? lock_idx_q : search_idx;
        grant_active = lock_q | search_hit;
        grant_next   = (grant_idx == IdxW'(NumLinks - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        host_a_ready_o = '0;
        if (grant_active) begin
            host_a_ready_o[grant_idx] = dev_a_ready_i;
        end
        dev_a_valid_o = grant_active & host_a_valid_i[grant_idx];
        dev_a_o       = a_payload[grant_idx];
    end

    logic [2:0]      a_opcode;
    logic [2:0]      a_size;
    logic            a_multi;
    logic [CntW-1:0] a_beats;
    logic            a_accept;

    always_comb begin
        a_opcode = dev_a_o[ABits-1 -: 3];
        a_size   = dev_a_o[ABits-7 -: 3];
        a_multi  = (a_opcode == 3'd0 || a_opcode == 3'd1) && (32'(a_size) > BeatShift);
        a_beats  = a_multi ? (CntW'(1) << (a_size - 3'(BeatShift))) : CntW'(1);
        a_accept = dev_a_valid_o & dev_a_ready_i;
    end

    // The pointer only advances when a whole message has gone through.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        if (a_accept) begin
            if (lock_q) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    lock_d = 1'b0;
                    rr_d   = grant_next;
                end
            end else if (a_multi) begin
                lock_d     = 1'b1;
                lock_idx_d = grant_idx;
                cnt_d      = a_beats - 1'b1;
            end else begin
                rr_d = grant_next;
            end
        end
    end

    logic [SourceWidth-1:0] d_source;
    logic [IdxW-1:0]        d_idx;
    logic                   d_match;

    always_comb begin
        d_source = dev_d_i[DSrcLsb +: SourceWidth];
        d_idx    = '0;
        d_match  = 1'b0;
        for (int k = NumLinks - 1; k >= 0; k--) begin
            if ((d_source & ~SourceMask[k*SourceWidth +: SourceWidth]) ==
                (SourceBase[k*SourceWidth +: SourceWidth] & ~SourceMask[k*SourceWidth +: SourceWidth])) begin
                d_match = 1'b1;
                d_idx   = IdxW'(k);
            end
        end
    end

    // Unroutable beats are swallowed so the device never stalls on them.
    always_comb begin
        host_d_valid_o = '0;
        if (d_match) begin
            host_d_valid_o[d_idx] = dev_d_valid_i;
        end
        dev_d_ready_o = d_match ? host_d_ready_i[d_idx] : 1'b1;
        host_d_o      = {NumLinks{dev_d_i}};
        route_err_d   = route_err_q | (dev_d_valid_i & ~d_match);
    end

    assign route_err_o = route_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            cnt_q       <= '0;
            route_err_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            cnt_q       <= cnt_d;
            route_err_q <= route_err_d;
        end
    end

endmodule
